operand_sign_split: RTL and testbench

- Input conditioning stage of the signed convolution multiplier.
- Accepts two signed two's-complement operands over a valid/ready handshake.
- Emits their unsigned magnitudes plus the product sign bit X, which the multiplier's output sign-restore stage consumes.
- Registered with a 2-entry skid buffer: full throughput, registered in_ready, 1-cycle latency.

---
 rtl/mult_pkg.sv | 14 +
 rtl/abs_value_in.sv | 20 ++
 rtl/operand_sign_split.sv | 57 +++++
 tb/tb_operand_sign_split.sv | 111 +++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, types and skid-buffer state for the signed multiplier
package mult_pkg;
  localparam int OPERAND_W = 8;
  localparam int PRODUCT_W = 16;
  typedef logic signed [OPERAND_W-1:0] operand_t;
  typedef logic [OPERAND_W-1:0] mag_t;
  typedef struct packed {
    mag_t mag_a;
    mag_t mag_b;
    logic sign_x;
    logic zero_op;
  } split_t;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t;
endpackage

// File: rtl/abs_value_in.sv
// abs_value_in: conditional two's-complement negator as a full-adder ripple chain
module abs_value_in #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] mag,
  output logic         neg
);
  logic [W-1:0] c;
  assign neg = x[W-1];
  assign c[0] = neg;
  for (genvar i = 0; i < W; i++) begin : g_fa
    logic bi;
    assign bi = x[i] ^ neg;
    assign mag[i] = 1'b0 ^ bi ^ c[i];
    if (i < W - 1) begin : g_c
      assign c[i+1] = (1'b0 & bi) | (c[i] & (1'b0 ^ bi));
    end
  end
endmodule

// File: rtl/operand_sign_split.sv
// operand_sign_split: operand magnitude/sign split behind a 2-entry skid buffer
module operand_sign_split
  import mult_pkg::*;
#(
  parameter int WIDTH = OPERAND_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             sign_x,
  output logic             zero_op
);
  skid_state_t state, state_d;
  split_t main_q, skid_q, nxt;
  logic neg_a, neg_b, accept, pop;
  abs_value_in #(.W(WIDTH)) u_abs_a (.x(a), .mag(nxt.mag_a), .neg(neg_a));
  abs_value_in #(.W(WIDTH)) u_abs_b (.x(b), .mag(nxt.mag_b), .neg(neg_b));
  assign nxt.zero_op = (a == '0) | (b == '0);
  assign nxt.sign_x = (neg_a ^ neg_b) & ~nxt.zero_op;
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign accept = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_comb begin
    state_d = state;
    case (state)
      EMPTY: state_d = accept ? BUSY : EMPTY;
      BUSY:  state_d = (accept & ~pop) ? FULL : (~accept & pop) ? EMPTY : BUSY;
      FULL:  state_d = pop ? BUSY : FULL;
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_d;
  // main takes fresh data when empty or draining in step; skid catches the stalled arrival
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (accept & (state == EMPTY | pop)) main_q <= nxt;
      else if (pop & state == FULL) main_q <= skid_q;
      if (accept & ~pop & state == BUSY) skid_q <= nxt;
    end
  assign mag_a = main_q.mag_a;
  assign mag_b = main_q.mag_b;
  assign sign_x = main_q.sign_x;
  assign zero_op = main_q.zero_op;
endmodule

// File: tb/tb_operand_sign_split.sv
// tb_operand_sign_split: directed and random scoreboard bench for operand_sign_split
module tb_operand_sign_split;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [7:0] a = 0, b = 0;
  logic in_ready, out_valid, sign_x, zero_op;
  logic [7:0] mag_a, mag_b;
  int errors = 0, checks = 0, pops = 0;
  logic [17:0] sb[$];
  logic acc;
  always #5 clk = ~clk;
  operand_sign_split dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .mag_a(mag_a), .mag_b(mag_b),
    .sign_x(sign_x), .zero_op(zero_op)
  );
  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [17:0] model(input logic [7:0] x, input logic [7:0] y);
    int ix, iy;
    logic [7:0] mx, my;
    logic z;
    ix = int'($signed(x));
    iy = int'($signed(y));
    mx = 8'(ix < 0 ? -ix : ix);
    my = 8'(iy < 0 ? -iy : iy);
    z = (ix == 0) || (iy == 0);
    return {mx, my, ((ix < 0) != (iy < 0)) && !z, z};
  endfunction
  task automatic tick(input logic v, input logic [7:0] xa, input logic [7:0] xb,
                      input logic ordy, output logic accepted);
    in_valid = v; a = xa; b = xb; out_ready = ordy;
    #1;
    accepted = v & in_ready;
    if (accepted) sb.push_back(model(xa, xb));
    if (out_valid && out_ready) begin
      pops++;
      if (sb.size() == 0) check("sb_underflow", 18'(sb.size()), 18'd1);
      else check("out", {mag_a, mag_b, sign_x, zero_op}, sb.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drain();
    int n = 0;
    logic t;
    while ((sb.size() != 0 || out_valid) && n < 20) begin
      tick(0, 8'h00, 8'h00, 1, t);
      n++;
    end
    check("drain_timeout", 18'(n < 20), 18'd1);
    check("drain_empty", 18'(sb.size()), 18'd0);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_state", {out_valid, in_ready, mag_a, mag_b, sign_x, zero_op}, {1'b0, 1'b1, 18'd0});
    rst = 0;
    @(negedge clk);
    tick(1, 8'hFB, 8'h03, 1, acc);
    #1 check("sign_mag", {mag_a, mag_b, sign_x, zero_op}, {8'd5, 8'd3, 1'b1, 1'b0});
    tick(1, 8'h80, 8'h80, 1, acc);
    #1 check("most_neg", {mag_a, mag_b, sign_x, zero_op}, {8'h80, 8'h80, 1'b0, 1'b0});
    tick(1, 8'h7F, 8'hFF, 1, acc);
    #1 check("max_minus1", {mag_a, mag_b, sign_x, zero_op}, {8'd127, 8'd1, 1'b1, 1'b0});
    tick(1, 8'h00, 8'hF9, 1, acc);
    #1 check("zero_op", {mag_a, mag_b, sign_x, zero_op}, {8'd0, 8'd7, 1'b0, 1'b1});
    drain();
    tick(1, 8'h01, 8'h02, 0, acc);
    tick(1, 8'hFD, 8'h04, 0, acc);
    check("accept_two", 18'(sb.size()), 18'd2);
    check("full_in_ready", {17'd0, in_ready}, 18'd0);
    tick(1, 8'h05, 8'hFA, 0, acc);
    tick(1, 8'h05, 8'hFA, 0, acc);
    check("no_accept_full", 18'(sb.size()), 18'd2);
    check("frozen", {out_valid, mag_a, mag_b, sign_x}, {1'b1, 8'd1, 8'd2, 1'b0});
    tick(1, 8'h05, 8'hFA, 1, acc);
    check("pop_no_accept", {17'd0, acc}, 18'd0);
    check("ready_after_pop", {17'd0, in_ready}, 18'd1);
    tick(1, 8'h05, 8'hFA, 1, acc);
    check("accept_5", {17'd0, acc}, 18'd1);
    tick(1, 8'hF9, 8'hF8, 1, acc);
    check("accept_7", {17'd0, acc}, 18'd1);
    drain();
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1, 8'($urandom), 8'($urandom), 1, acc);
      check("tp_accept", {17'd0, acc}, 18'd1);
    end
    tick(0, 8'h00, 8'h00, 1, acc);
    check("tp_pops", 18'(pops), 18'd16);
    check("tp_empty", {17'd0, out_valid}, 18'd0);
    tick(1, 8'h11, 8'h22, 0, acc);
    tick(1, 8'h33, 8'h44, 0, acc);
    rst = 1;
    #1 check("async_rst", {16'd0, out_valid, in_ready}, {16'd0, 1'b0, 1'b1});
    sb.delete();
    @(negedge clk);
    rst = 0;
    tick(1, 8'h02, 8'hFE, 1, acc);
    #1 check("post_rst", {out_valid, mag_a, mag_b, sign_x, zero_op}, {1'b1, 8'd2, 8'd2, 1'b1, 1'b0});
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
